// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and defaults for the multi-channel clock divider
package clk_div_pkg;

    typedef enum logic {DIV_SQUARE = 1'b0, DIV_PULSE = 1'b1} div_mode_e;

    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one programmable divider with shadowed ratio/mode, live enable and tick strobe
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    input  logic             mode,
    input  logic             en,
    output logic             clkout,
    output logic             tick,
    output logic             active
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;
    logic             wave_nxt;
    logic             valid;
    div_mode_e        mode_q;

    assign valid  = div_q > ONE;
    assign active = valid;
    assign last   = div_q - ONE;

    // next count and the waveform it produces; half = ceil(N/2) without overflowing at N = 2^CNT_W-1
    always_comb begin
        half     = {1'b0, div_q[CNT_W-1:1]} + {{(CNT_W-1){1'b0}}, div_q[0]};
        cnt_nxt  = (cnt == last) ? '0 : cnt + ONE;
        wave_nxt = (mode_q == DIV_PULSE) ? (cnt_nxt == '0) : (cnt_nxt < half);
    end

    // reset > load > idle-on-invalid > count-while-enabled; disabled cycles freeze cnt and clkout
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q  <= '0;
            mode_q <= DIV_SQUARE;
            cnt    <= '0;
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else if (load) begin
            div_q  <= div;
            mode_q <= div_mode_e'(mode);
            cnt    <= '0;
            clkout <= div > ONE;
            tick   <= 1'b0;
        end else if (!valid) begin
            cnt    <= '0;
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else if (en) begin
            cnt    <= cnt_nxt;
            clkout <= wave_nxt;
            tick   <= cnt_nxt == last;
        end else begin
            tick   <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock-enable dividers sharing one load strobe
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [NUM_CH*CNT_W-1:0] div,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       en,
    output logic [NUM_CH-1:0]       clkout,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(.CNT_W(CNT_W)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .div    (div[i*CNT_W +: CNT_W]),
            .mode   (mode[i]),
            .en     (en[i]),
            .clkout (clkout[i]),
            .tick   (tick[i]),
            .active (active[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized scoreboard bench against a cycle-level behavioural model
module tb_clk_div_multi;
  localparam int NCH = 4;
  localparam int CW  = 8;
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load = 1'b0;
  logic [NCH*CW-1:0] div = '0;
  logic [NCH-1:0]    mode = '0;
  logic [NCH-1:0]    en = '0;
  logic [NCH-1:0]    clkout;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    active;
  int n_chk = 0;
  int n_fail = 0;
  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .div    (div),
    .mode   (mode),
    .en     (en),
    .clkout (clkout),
    .tick   (tick),
    .active (active)
  );
  always #5 clk = ~clk;
  int               mn[NCH];
  int               mc[NCH];
  bit               mm[NCH];
  bit [NCH-1:0]     mclk = '0;
  bit [NCH-1:0]     mtk = '0;
  logic [3*NCH-1:0] exp_q[$];
  function automatic bit [NCH-1:0] model_act();
    bit [NCH-1:0] a;
    for (int ch = 0; ch < NCH; ch++) a[ch] = mn[ch] >= 2;
    return a;
  endfunction
  task automatic model_update();
    for (int ch = 0; ch < NCH; ch++) begin
      if (!reset) begin
        mn[ch] = 0; mm[ch] = 0; mc[ch] = 0; mclk[ch] = 0; mtk[ch] = 0;
      end else if (load) begin
        mn[ch] = int'(div[ch*CW +: CW]);
        mm[ch] = mode[ch];
        mc[ch] = 0;
        mclk[ch] = mn[ch] >= 2;
        mtk[ch] = 0;
      end else if (mn[ch] < 2) begin
        mc[ch] = 0; mclk[ch] = 0; mtk[ch] = 0;
      end else if (en[ch]) begin
        mc[ch] = (mc[ch] + 1) % mn[ch];
        mclk[ch] = mm[ch] ? (mc[ch] == 0) : (mc[ch] < (mn[ch] + 1) / 2);
        mtk[ch] = mc[ch] == mn[ch] - 1;
      end else begin
        mtk[ch] = 0;
      end
    end
  endtask
  task automatic step();
    model_update();
    @(posedge clk);
    exp_q.push_back({mclk, mtk, model_act()});
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic set_div(input int ch, input int v);
    div[ch*CW +: CW] = CW'(v);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3*NCH-1:0] e;
      e = exp_q.pop_front();
      n_chk++;
      if ({clkout, tick, active} !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got clkout=%b tick=%b active=%b expected clkout=%b tick=%b active=%b",
                 $time, clkout, tick, active, e[3*NCH-1 -: NCH], e[2*NCH-1 -: NCH], e[NCH-1:0]);
      end
    end
  end
  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      mn[ch] = 0; mc[ch] = 0; mm[ch] = 0;
    end
    reset = 0;
    run(3);
    n_chk++;
    if ({clkout, tick, active} !== '0) begin
      n_fail++;
      $display("FAIL reset state t=%0t clkout=%b tick=%b active=%b", $time, clkout, tick, active);
    end
    reset = 1;
    en = '1;
    run(3);
    set_div(0, 10); set_div(1, 5); set_div(2, 4); set_div(3, 255);
    mode = 4'b0100;
    load = 1; run(1); load = 0;
    run(40);
    for (int k = 0; k < 20 && mc[0] != 3; k++) step();
    n_chk++;
    if (mc[0] != 3) begin
      n_fail++;
      $display("FAIL wait for ch0 phase 3 expired t=%0t phase=%0d", $time, mc[0]);
    end
    en[0] = 0; run(7); en[0] = 1;
    run(30);
    set_div(0, 6); set_div(1, 6); mode = '0; en[1] = 0;
    load = 1; run(1); load = 0;
    run(2); en[1] = 1; run(20);
    set_div(0, 3); run(10);
    load = 1; run(1); load = 0; run(20);
    set_div(0, 4);
    load = 1; run(1); load = 0; run(2);
    load = 1; run(1); load = 0; run(10);
    set_div(0, 0); set_div(1, 1); set_div(2, 7); set_div(3, 255); mode = 4'b0100;
    load = 1; run(1); load = 0;
    run(600);
    reset = 0; run(1); reset = 1; run(10);
    set_div(0, 5); set_div(1, 6);
    load = 1; run(1); load = 0; run(7);
    load = 1; reset = 0; run(1); reset = 1; load = 0; run(8);
    for (int k = 0; k < 2000; k++) begin
      en = NCH'($urandom);
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        for (int ch = 0; ch < NCH; ch++) set_div(ch, $urandom_range(0, 12));
        mode = NCH'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        set_div($urandom_range(0, NCH - 1), $urandom_range(0, 12));
      end
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1; load = 0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
